ptw_arbiter: RTL and testbench

PTW_ARBITER -- requirements
Module: ptw_arbiter

---
 rtl/mmu_pkg.sv | 73 +++++++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/ptw_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ptw_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg
//   Shared MMU types for the TLB <-> page-table-walker (PTW) link and the
//   PTW arbiter.
//
//   Contents:
//     MAX_REQ / ARB_IDX_SIZE : widest supported requester count and the
//                              width of a requester index.
//     ptw_arb_state_t        : arbiter FSM states (ARB_IDLE, ARB_BUSY).
//     tlb_ptw_comm_t         : TLB -> PTW request bundle (req.*).
//     ptw_tlb_comm_t         : PTW -> TLB bundle (ptw_ready, resp,
//                              invalidate_tlb, ptw_status).
//     wrap_idx()             : modular index helper for round-robin search.
// -----------------------------------------------------------------------------
package mmu_pkg;

  localparam int MAX_REQ      = 4;
  localparam int ARB_IDX_SIZE = $clog2(MAX_REQ);

  localparam int VPN_W  = 27;
  localparam int ASID_W = 9;
  localparam int PPN_W  = 44;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } ptw_arb_state_t;

  // Page-walk request issued by a TLB on a miss.
  typedef struct packed {
    logic              valid;
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic [1:0]        prv;
    logic              store;
    logic              fetch;
  } tlb_ptw_req_t;

  typedef struct packed {
    tlb_ptw_req_t req;
  } tlb_ptw_comm_t;

  // Result of a completed walk.
  typedef struct packed {
    logic             valid;
    logic             error;
    logic [PPN_W-1:0] ppn;
    logic [7:0]       flags;
  } ptw_resp_t;

  // Translation-relevant architectural status mirrored to every TLB.
  typedef struct packed {
    logic [1:0]        prv;
    logic              sum;
    logic              mxr;
    logic [3:0]        mode;
    logic [ASID_W-1:0] asid;
  } ptw_status_t;

  typedef struct packed {
    logic        ptw_ready;
    ptw_resp_t   resp;
    logic        invalidate_tlb;
    ptw_status_t ptw_status;
  } ptw_tlb_comm_t;

  // Wraps v into [0, n) assuming 0 <= v < 2*n, which is all the search
  // loops ever need; avoids a general modulo operator in hardware.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational winner selection among NUM_REQ requesters. The search
//   starts at ptr_i and proceeds upward with wrap-around; the first asserted
//   request wins. Driving ptr_i with zero yields plain fixed priority
//   (lowest index wins).
//
//   Ports:
//     req_i   [NUM_REQ-1:0]      request vector
//     ptr_i   [ARB_IDX_SIZE-1:0] index at which the search starts (< NUM_REQ)
//     grant_o [NUM_REQ-1:0]      one-hot grant, all zero when no request
//     idx_o   [ARB_IDX_SIZE-1:0] binary index of the granted requester
//                                (zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [ARB_IDX_SIZE-1:0] ptr_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic [ARB_IDX_SIZE-1:0] idx_o
);

  always_comb begin
    logic found;
    int   cand;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // Outer loop walks the priority order (pointer first); the inner loop
    // turns the computed position into a constant bit select.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_idx(int'(ptr_i) + k, NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == cand) && req_i[j]) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = ARB_IDX_SIZE'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// -----------------------------------------------------------------------------
// ptw_arbiter
//   Shares a single page-table walker among NUM_REQ TLBs. At most one walk
//   is outstanding: in IDLE the selected requester's request is passed
//   straight through to the PTW and only that requester sees ptw_ready; once
//   the PTW accepts, the arbiter sits in BUSY until the PTW's response, which
//   is steered to the owning TLB alone. TLB invalidates and PTW status are
//   broadcast to every TLB at all times.
//
//   Build option:
//     PTW_ARB_RR_EN defined   : round-robin selection; the search pointer
//                               moves to owner+1 on every grant.
//     PTW_ARB_RR_EN undefined : fixed priority, lowest index wins.
//
//   Parameters:
//     NUM_REQ         number of TLB requesters (2..4)
//
//   Ports:
//     clk_i           system clock
//     rst_i           synchronous active-high reset
//     tlb_ptw_comm_i  [NUM_REQ] per-TLB walk request
//     ptw_tlb_comm_o  [NUM_REQ] per-TLB ready / response / invalidate / status
//     tlb_ptw_comm_o  request to the PTW
//     ptw_tlb_comm_i  PTW ready / response / invalidate / status
//     owner_o         index of the requester that last won the PTW
//     busy_o          high while a walk is outstanding
// -----------------------------------------------------------------------------
module ptw_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  tlb_ptw_comm_t [NUM_REQ-1:0]   tlb_ptw_comm_i,
  output ptw_tlb_comm_t [NUM_REQ-1:0]   ptw_tlb_comm_o,
  output tlb_ptw_comm_t                 tlb_ptw_comm_o,
  input  ptw_tlb_comm_t                 ptw_tlb_comm_i,
  output logic [ARB_IDX_SIZE-1:0]       owner_o,
  output logic                          busy_o
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("ptw_arbiter: NUM_REQ must be in 2..%0d", MAX_REQ);
  end

  ptw_arb_state_t            state_reg;
  logic [ARB_IDX_SIZE-1:0]   owner_reg;
  logic                      busy_reg;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        grant;
  logic [ARB_IDX_SIZE-1:0]   win_idx;
  logic [ARB_IDX_SIZE-1:0]   search_ptr;
  logic                      in_idle;
  logic                      in_busy;
  logic                      win_valid;
  logic                      grant_fire;
  tlb_ptw_req_t              req_mux;

  assign in_idle = (state_reg == ARB_IDLE);
  assign in_busy = (state_reg == ARB_BUSY);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_valid
    assign req_valid[gi] = tlb_ptw_comm_i[gi].req.valid;
  end

  // ---------------------------------------------------------------------------
  // Search pointer
  // ---------------------------------------------------------------------------
`ifdef PTW_ARB_RR_EN
  logic [ARB_IDX_SIZE-1:0] ptr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else if (grant_fire) begin
      // The next search starts just past the requester that was served.
      ptr_reg <= ARB_IDX_SIZE'(wrap_idx(int'(win_idx) + 1, NUM_REQ));
    end
  end

  assign search_ptr = ptr_reg;
`else
  assign search_ptr = '0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (search_ptr),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  assign win_valid  = |grant;
  // A walk starts only when the PTW accepts while a requester is still asking;
  // a request withdrawn before ready simply re-arbitrates next cycle.
  assign grant_fire = in_idle && win_valid && ptw_tlb_comm_i.ptw_ready;

  // ---------------------------------------------------------------------------
  // Request path to the PTW: one-hot AND-OR mux, zero when busy or no request
  // ---------------------------------------------------------------------------
  always_comb begin
    req_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        req_mux = req_mux | tlb_ptw_comm_i[i].req;
      end
    end
  end

  assign tlb_ptw_comm_o.req = in_idle ? req_mux : '0;

  // ---------------------------------------------------------------------------
  // Response path to each TLB
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tlb_out
    logic is_owner;

    assign is_owner = in_busy && (owner_reg == ARB_IDX_SIZE'(gi));

    assign ptw_tlb_comm_o[gi].ptw_ready =
      in_idle && grant[gi] && ptw_tlb_comm_i.ptw_ready;

    // Response payload is shared; only the valid strobe is steered, so a
    // response arriving in IDLE (e.g. a walk killed by reset) reaches no one.
    assign ptw_tlb_comm_o[gi].resp.valid = is_owner && ptw_tlb_comm_i.resp.valid;
    assign ptw_tlb_comm_o[gi].resp.error = ptw_tlb_comm_i.resp.error;
    assign ptw_tlb_comm_o[gi].resp.ppn   = ptw_tlb_comm_i.resp.ppn;
    assign ptw_tlb_comm_o[gi].resp.flags = ptw_tlb_comm_i.resp.flags;

    assign ptw_tlb_comm_o[gi].invalidate_tlb = ptw_tlb_comm_i.invalidate_tlb;
    assign ptw_tlb_comm_o[gi].ptw_status     = ptw_tlb_comm_i.ptw_status;
  end

  // ---------------------------------------------------------------------------
  // FSM. Invalidates never affect it: the owner keeps waiting for its response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (grant_fire) begin
            state_reg <= ARB_BUSY;
            owner_reg <= win_idx;
            busy_reg  <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (ptw_tlb_comm_i.resp.valid) begin
            state_reg <= ARB_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign owner_o = owner_reg;
  assign busy_o  = busy_reg;

endmodule

// File: tb/tb_ptw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ptw_arbiter
//   Self-checking bench for ptw_arbiter with NUM_REQ = 3. Directed scenarios
//   (single walk, contention, invalidate mid-walk, cancelled request, reset
//   while busy, spurious response) are followed by a randomized phase. Every
//   cycle all outputs are compared with a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_ptw_arbiter;
  import mmu_pkg::*;

  localparam int N = 3;
`ifdef PTW_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  tlb_ptw_comm_t [N-1:0]   tlb_in;
  ptw_tlb_comm_t [N-1:0]   tlb_out;
  tlb_ptw_comm_t           ptw_req;
  ptw_tlb_comm_t           ptw_in;
  logic [ARB_IDX_SIZE-1:0] owner;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is a walk outstanding, who owns it, where the search starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int grant_log[$];

  ptw_arbiter #(
    .NUM_REQ (N)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tlb_ptw_comm_i (tlb_in),
    .ptw_tlb_comm_o (tlb_out),
    .tlb_ptw_comm_o (ptw_req),
    .ptw_tlb_comm_i (ptw_in),
    .owner_o        (owner),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic tlb_ptw_req_t mk_req(input bit v);
    tlb_ptw_req_t r;
    r.valid = v;
    r.vpn   = VPN_W'($urandom);
    r.asid  = ASID_W'($urandom);
    r.prv   = 2'($urandom);
    r.store = 1'($urandom);
    r.fetch = 1'($urandom);
    return r;
  endfunction

  function automatic ptw_resp_t mk_resp(input bit v);
    ptw_resp_t r;
    r.valid = v;
    r.error = 1'($urandom);
    r.ppn   = PPN_W'({$urandom, $urandom});
    r.flags = 8'($urandom);
    return r;
  endfunction

  function automatic ptw_status_t mk_status();
    ptw_status_t s;
    s.prv  = 2'($urandom);
    s.sum  = 1'($urandom);
    s.mxr  = 1'($urandom);
    s.mode = 4'($urandom);
    s.asid = ASID_W'($urandom);
    return s;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) tlb_in[i].req = mk_req(1'b0);
    ptw_in.ptw_ready      = 1'b0;
    ptw_in.resp           = mk_resp(1'b0);
    ptw_in.invalidate_tlb = 1'b0;
    ptw_in.ptw_status     = mk_status();
  endtask

  // One clock cycle: inputs were driven at the preceding negedge. Check all
  // outputs against the model, then advance the model at the posedge.
  task automatic step();
    int           w;
    tlb_ptw_req_t exp_req;
    ptw_resp_t    exp_resp;
    #1;
    w = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && tlb_in[i].req.valid) w = i;
      end
    end
    check_eq("busy", busy, m_busy);
    check_eq("owner", owner, m_owner);
    exp_req = '0;
    if (w >= 0) exp_req = tlb_in[w].req;
    check_eq("ptw_req", ptw_req.req, exp_req);
    for (int i = 0; i < N; i++) begin
      exp_resp       = ptw_in.resp;
      exp_resp.valid = m_busy && (m_owner == i) && ptw_in.resp.valid;
      check_eq($sformatf("ready%0d", i), tlb_out[i].ptw_ready, (w == i) && ptw_in.ptw_ready);
      check_eq($sformatf("resp%0d", i), tlb_out[i].resp, exp_resp);
      check_eq($sformatf("inval%0d", i), tlb_out[i].invalidate_tlb, ptw_in.invalidate_tlb);
      check_eq($sformatf("status%0d", i), tlb_out[i].ptw_status, ptw_in.ptw_status);
      if (tlb_out[i].ptw_ready === 1'b1) begin
        grant_log.push_back(i);
        $display("[TB] t=%0t grant tlb%0d vpn=%h", $time, i, ptw_req.req.vpn);
      end
      if (tlb_out[i].resp.valid === 1'b1)
        $display("[TB] t=%0t resp  tlb%0d ppn=%h", $time, i, tlb_out[i].resp.ppn);
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (w >= 0 && ptw_in.ptw_ready) begin
        m_busy  = 1'b1;
        m_owner = w;
        if (RR_MODE) m_ptr = (w + 1) % N;
      end
    end else if (ptw_in.resp.valid) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Finish any outstanding walk; bounded so a stuck DUT cannot hang the run.
  task automatic drain();
    idle_inputs();
    for (int c = 0; c < 8 && (m_busy || busy === 1'b1); c++) begin
      ptw_in.resp = mk_resp(1'b1);
      step();
    end
    idle_inputs();
    check_eq("drain_idle", busy, 1'b0);
  endtask

  // Grant requester `r` (only one valid) so the arbiter ends up BUSY with it.
  task automatic grant_to(input int r);
    idle_inputs();
    tlb_in[r].req    = mk_req(1'b1);
    ptw_in.ptw_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    m_busy = 1'b0; m_owner = 0; m_ptr = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    do_reset();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_owner", owner, '0);

    // Single request from TLB0, 5-cycle walk.
    idle_inputs();
    tlb_in[0].req     = mk_req(1'b1);
    tlb_in[0].req.vpn = 27'h12345;
    ptw_in.ptw_ready  = 1'b1;
    #1;
    check_eq("single_vpn", ptw_req.req.vpn, 27'h12345);
    step();
    idle_inputs();
    check_eq("single_busy", busy, 1'b1);
    repeat (4) step();
    ptw_in.resp = mk_resp(1'b1);
    #1;
    check_eq("single_resp0", tlb_out[0].resp.valid, 1'b1);
    check_eq("single_resp1", tlb_out[1].resp.valid, 1'b0);
    step();
    idle_inputs();
    check_eq("single_idle", busy, 1'b0);
    step();

    // Contention between TLB0 and TLB1; PTW answers one cycle after grant.
    do_reset();
    grant_log.delete();
    for (int c = 0; c < 12; c++) begin
      tlb_in[0].req    = mk_req(1'b1);
      tlb_in[1].req    = mk_req(1'b1);
      tlb_in[2].req    = mk_req(1'b0);
      ptw_in.ptw_ready = 1'b1;
      ptw_in.resp      = mk_resp(m_busy);
      step();
    end
    check_eq("contend_count", grant_log.size() >= 4, 1'b1);
    if (grant_log.size() >= 4) begin
      for (int g = 0; g < 4; g++)
        check_eq($sformatf("contend_grant%0d", g), grant_log[g], RR_MODE ? (g % 2) : 0);
    end
    drain();

    // Invalidate while TLB1 owns the walk.
    do_reset();
    grant_to(1);
    ptw_in.invalidate_tlb = 1'b1;
    ptw_in.ptw_status     = mk_status();
    #1;
    for (int i = 0; i < N; i++)
      check_eq($sformatf("inv_bcast%0d", i), tlb_out[i].invalidate_tlb, 1'b1);
    step();
    idle_inputs();
    step();
    check_eq("inv_stay_busy", busy, 1'b1);
    check_eq("inv_owner", owner, 2'd1);
    ptw_in.resp = mk_resp(1'b1);
    #1;
    check_eq("inv_resp1", tlb_out[1].resp.valid, 1'b1);
    check_eq("inv_resp0", tlb_out[0].resp.valid, 1'b0);
    step();
    idle_inputs();
    step();

    // Cancelled request: TLB1 withdraws before ready, then TLB0 wins.
    do_reset();
    tlb_in[1].req = mk_req(1'b1);
    repeat (2) step();
    tlb_in[1].req    = mk_req(1'b0);
    tlb_in[0].req    = mk_req(1'b1);
    ptw_in.ptw_ready = 1'b1;
    #1;
    check_eq("cancel_ready0", tlb_out[0].ptw_ready, 1'b1);
    step();
    check_eq("cancel_busy", busy, 1'b1);
    check_eq("cancel_owner", owner, '0);
    drain();

    // Reset while TLB1 owns a walk; the late response must go nowhere.
    do_reset();
    grant_to(1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstbusy_busy", busy, 1'b0);
    check_eq("rstbusy_owner", owner, '0);
    ptw_in.resp = mk_resp(1'b1);
    #1;
    for (int i = 0; i < N; i++)
      check_eq($sformatf("late_resp%0d", i), tlb_out[i].resp.valid, 1'b0);
    step();

    // Spurious response while idle.
    idle_inputs();
    ptw_in.resp = mk_resp(1'b1);
    step();
    check_eq("spurious_idle", busy, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) tlb_in[i].req = mk_req($urandom_range(0, 1) == 1);
      ptw_in.ptw_ready      = ($urandom_range(0, 1) == 1);
      ptw_in.resp           = mk_resp(m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0));
      ptw_in.invalidate_tlb = ($urandom_range(0, 9) == 0);
      ptw_in.ptw_status     = mk_status();
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
